// File: rtl/cp0_reg_pkg.sv
// -----------------------------------------------------------------------------
// cp0_reg_pkg
// Shared definitions for the CP0 register block:
//   - CP0 register numbers (mfc0/mtc0 rd field)
//   - exception type codes as resolved by the MEM stage
//   - reset constants for Status / Config / PRId
//   - Cause software-writable bit mask
//   - exc_decode(): maps an exception type to its Cause.ExcCode
// No ports.
// -----------------------------------------------------------------------------
package cp0_reg_pkg;

   // register numbers
   localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_REG_EPC     = 5'd14;
   localparam logic [4:0] CP0_REG_PRID    = 5'd15;
   localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

   // exception types from MEM
   localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
   localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
   localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
   localparam logic [31:0] EXC_INST_INV  = 32'h0000_000A;
   localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000C;
   localparam logic [31:0] EXC_TRAP      = 32'h0000_000D;
   localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

   // reset values
   localparam logic [31:0] STATUS_RST = 32'h1000_0000;   // CU0 set
   localparam logic [31:0] CONFIG_RST = 32'h0000_8000;
   localparam logic [31:0] PRID_RST   = 32'h004C_0102;

   // Cause bits software may write: IP[1:0], WP, IV
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   // field positions
   localparam int STATUS_EXL = 1;
   localparam int CAUSE_BD   = 31;

   typedef struct packed {
      logic       hit;    // type has a defined ExcCode
      logic [4:0] code;
   } exc_code_t;

   function automatic exc_code_t exc_decode(input logic [31:0] t);
      exc_code_t r;
      r = '{hit: 1'b0, code: 5'd0};
      case (t)
         EXC_INTERRUPT: r = '{hit: 1'b1, code: 5'd0};
         EXC_SYSCALL:   r = '{hit: 1'b1, code: 5'd8};
         EXC_BREAK:     r = '{hit: 1'b1, code: 5'd9};
         EXC_INST_INV:  r = '{hit: 1'b1, code: 5'd10};
         EXC_TRAP:      r = '{hit: 1'b1, code: 5'd13};
         EXC_OVERFLOW:  r = '{hit: 1'b1, code: 5'd12};
         default:       r = '{hit: 1'b0, code: 5'd0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count / Compare registers and the sticky timer interrupt.
// Only compiled when CP0_TIMER_EN is defined.
// Ports:
//   clk, rst            clock, async active-low reset
//   i_we_count          load Count from i_wdata (no increment that cycle)
//   i_we_compare        load Compare from i_wdata, clears timer interrupt
//   i_wdata [31:0]      write data
//   o_count, o_compare  current register values
//   o_timer_int         registered, sticky timer interrupt request
// -----------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we_count,
   input  logic        i_we_compare,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_timer_int
);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_timer_int;
   logic        w_match;

   // compare of zero means "timer disarmed"
   assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= 32'd0;
         r_compare   <= 32'd0;
         r_timer_int <= 1'b0;
      end else begin
         r_count <= i_we_count ? i_wdata : r_count + 32'd1;
         if (i_we_compare) begin
            r_compare   <= i_wdata;
            r_timer_int <= 1'b0;          // clear beats a same-cycle match
         end else if (w_match) begin
            r_timer_int <= 1'b1;
         end
      end
   end

   assign o_count     = r_count;
   assign o_compare   = r_compare;
   assign o_timer_int = r_timer_int;

endmodule
`endif

// File: rtl/cp0_reg.sv
// -----------------------------------------------------------------------------
// cp0_reg
// CP0 register block sitting after MEM/WB. Applies mtc0 writes from WB and the
// resolved exception from MEM, keeps Status/Cause/EPC (plus Count/Compare when
// the timer is built), and serves combinational mfc0 reads with a WB bypass.
// Build option: CP0_TIMER_EN -- when undefined, Count/Compare read 0, writes
// to them are dropped and timer_int_o is tied low.
// Ports:
//   clk, rst                    clock, async active-low reset
//   we_i, waddr_i, wdata_i      mtc0 write request
//   raddr_i / rdata_o           mfc0 read (combinational, bypassed)
//   int_i [5:0]                 hardware interrupt lines -> Cause.IP[7:2]
//   excepttype_i                exception type (0 none, 0x0E eret)
//   current_inst_addr_i         PC of excepting instruction
//   is_in_delayslot_i           excepting instruction is in a delay slot
//   count_o .. prid_o           current register values
//   timer_int_o                 timer interrupt request
// -----------------------------------------------------------------------------
module cp0_reg
   import cp0_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] rdata_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   logic [31:0] r_status;
   logic [31:0] r_cause;
   logic [31:0] r_epc;

   logic        w_exc;
   logic        w_eret;
   logic        w_wr;
   exc_code_t   w_dec;
   logic [31:0] w_cause_wr;
   logic [31:0] w_status_nxt;
   logic [31:0] w_cause_nxt;
   logic [31:0] w_epc_nxt;
   logic [31:0] w_count;
   logic [31:0] w_compare;
   logic        w_timer_int;

   assign w_exc  = (excepttype_i != EXC_NONE) && (excepttype_i != EXC_ERET);
   assign w_eret = (excepttype_i == EXC_ERET);
   // any exception (eret included) kills the WB write in the same cycle
   assign w_wr   = we_i && (excepttype_i == EXC_NONE);
   assign w_dec  = exc_decode(excepttype_i);

   // Cause as it would look after an mtc0: only the writable bits change
   assign w_cause_wr = (r_cause & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);

   // ---------------------------------------------------------------- timer
`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_we_count   (w_wr && (waddr_i == CP0_REG_COUNT)),
      .i_we_compare (w_wr && (waddr_i == CP0_REG_COMPARE)),
      .i_wdata      (wdata_i),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_timer_int  (w_timer_int)
   );
`else
   assign w_count     = 32'd0;
   assign w_compare   = 32'd0;
   assign w_timer_int = 1'b0;
`endif

   // ------------------------------------------------------- next-state comb
   always_comb begin
      w_status_nxt = r_status;
      if (w_wr && (waddr_i == CP0_REG_STATUS))
         w_status_nxt = wdata_i;
      if (w_exc)
         w_status_nxt[STATUS_EXL] = 1'b1;
      else if (w_eret)
         w_status_nxt[STATUS_EXL] = 1'b0;
   end

   always_comb begin
      w_cause_nxt = r_cause;
      if (w_wr && (waddr_i == CP0_REG_CAUSE))
         w_cause_nxt = w_cause_wr;
      // IP[7:2] tracks the pins every cycle, regardless of writes
      w_cause_nxt[15:10] = int_i;
      if (w_exc) begin
         if (w_dec.hit)
            w_cause_nxt[6:2] = w_dec.code;
         // nested exceptions keep the original BD/EPC
         if (!r_status[STATUS_EXL])
            w_cause_nxt[CAUSE_BD] = is_in_delayslot_i;
      end
   end

   always_comb begin
      w_epc_nxt = r_epc;
      if (w_wr && (waddr_i == CP0_REG_EPC))
         w_epc_nxt = wdata_i;
      if (w_exc && !r_status[STATUS_EXL])
         w_epc_nxt = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                       : current_inst_addr_i;
   end

   // --------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_status <= STATUS_RST;
         r_cause  <= 32'd0;
         r_epc    <= 32'd0;
      end else begin
         r_status <= w_status_nxt;
         r_cause  <= w_cause_nxt;
         r_epc    <= w_epc_nxt;
      end
   end

   // ---------------------------------------------------------------- read
   always_comb begin
      case (raddr_i)
         CP0_REG_COUNT:   rdata_o = w_count;
         CP0_REG_COMPARE: rdata_o = w_compare;
         CP0_REG_STATUS:  rdata_o = r_status;
         CP0_REG_CAUSE:   rdata_o = r_cause;
         CP0_REG_EPC:     rdata_o = r_epc;
         CP0_REG_PRID:    rdata_o = PRID_RST;
         CP0_REG_CONFIG:  rdata_o = CONFIG_RST;
         default:         rdata_o = 32'd0;
      endcase
      // WB -> EX bypass: return the value the write is about to commit
      if (w_wr && (waddr_i == raddr_i)) begin
         case (raddr_i)
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT,
            CP0_REG_COMPARE: rdata_o = wdata_i;
`endif
            CP0_REG_STATUS,
            CP0_REG_EPC:     rdata_o = wdata_i;
            CP0_REG_CAUSE:   rdata_o = w_cause_wr;
            default:         ;
         endcase
      end
   end

   assign count_o     = w_count;
   assign compare_o   = w_compare;
   assign status_o    = r_status;
   assign cause_o     = r_cause;
   assign epc_o       = r_epc;
   assign config_o    = CONFIG_RST;
   assign prid_o      = PRID_RST;
   assign timer_int_o = w_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// -----------------------------------------------------------------------------
// tb_cp0_reg
// Self-checking bench for cp0_reg. A behavioural model of the CP0 registers is
// stepped on every rising edge from the inputs applied; a negedge process
// compares all outputs (including the bypassed rdata_o) against it. Directed
// sequences pin the model with literal values, then randomized traffic runs.
// Honours CP0_TIMER_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [5:0]  int_in;
   logic [31:0] et;
   logic [31:0] pc;
   logic        ds;

   logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o;
   logic [31:0] config_o, prid_o;
   logic        timer_int_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // model state
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
   logic        m_tint;

   logic [31:0] codes [0:5] = '{32'h1, 32'h8, 32'h9, 32'hA, 32'hC, 32'hD};

   cp0_reg dut (
      .clk                 (clk),
      .rst                 (rst),
      .we_i                (we),
      .waddr_i             (waddr),
      .wdata_i             (wdata),
      .raddr_i             (raddr),
      .int_i               (int_in),
      .excepttype_i        (et),
      .current_inst_addr_i (pc),
      .is_in_delayslot_i   (ds),
      .rdata_o             (rdata_o),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .config_o            (config_o),
      .prid_o              (prid_o),
      .timer_int_o         (timer_int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   task automatic model_reset();
      m_count   = 32'd0;
      m_compare = 32'd0;
      m_status  = 32'h1000_0000;
      m_cause   = 32'd0;
      m_epc     = 32'd0;
      m_tint    = 1'b0;
   endtask

   // ExcCode is the type number itself, except interrupt which is code 0
   function automatic logic [4:0] code_of(input logic [31:0] t);
      return (t == 32'h1) ? 5'd0 : t[4:0];
   endfunction

   task automatic model_step();
      bit exc, eret, wr, old_exl;
      logic [31:0] c;
      exc     = (et != 0) && (et != 32'hE);
      eret    = (et == 32'hE);
      wr      = we && (et == 0);
      old_exl = m_status[1];
`ifdef CP0_TIMER_EN
      if (wr && waddr == 5'd11) m_tint = 1'b0;
      else if (m_count == m_compare && m_compare != 0) m_tint = 1'b1;
      if (wr && waddr == 5'd11) m_compare = wdata;
      m_count = (wr && waddr == 5'd9) ? wdata : m_count + 32'd1;
`endif
      c = m_cause;
      if (wr && waddr == 5'd13) c = (c & ~32'h00C0_0300) | (wdata & 32'h00C0_0300);
      c[15:10] = int_in;
      if (exc) begin
         c[6:2] = code_of(et);
         if (!old_exl) c[31] = ds;
      end
      m_cause = c;
      if (wr && waddr == 5'd12) m_status = wdata;
      if (exc)  m_status[1] = 1'b1;
      if (eret) m_status[1] = 1'b0;
      if (wr && waddr == 5'd14) m_epc = wdata;
      if (exc && !old_exl) m_epc = ds ? pc - 32'd4 : pc;
   endtask

   function automatic logic [31:0] m_read();
      logic [31:0] v;
      case (raddr)
         5'd9:  v = m_count;
         5'd11: v = m_compare;
         5'd12: v = m_status;
         5'd13: v = m_cause;
         5'd14: v = m_epc;
         5'd15: v = 32'h004C_0102;
         5'd16: v = 32'h0000_8000;
         default: v = 32'd0;
      endcase
      if (we && et == 0 && waddr == raddr) begin
`ifdef CP0_TIMER_EN
         if (raddr == 5'd9 || raddr == 5'd11) v = wdata;
`endif
         if (raddr == 5'd12 || raddr == 5'd14) v = wdata;
         if (raddr == 5'd13) v = (m_cause & ~32'h00C0_0300) | (wdata & 32'h00C0_0300);
      end
      return v;
   endfunction

   // ----------------------------------------------------- compare process
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",   count_o,   m_count);
         chk("compare", compare_o, m_compare);
         chk("status",  status_o,  m_status);
         chk("cause",   cause_o,   m_cause);
         chk("epc",     epc_o,     m_epc);
         chk("config",  config_o,  32'h0000_8000);
         chk("prid",    prid_o,    32'h004C_0102);
         chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
         chk("rdata",   rdata_o,   m_read());
      end
   end

   // ----------------------------------------------------------- driver
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0; et = '0; pc = '0; ds = 1'b0;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      idle();
   endtask

   task automatic wait_count(input logic [31:0] v, input int lim);
      int n = 0;
      while (count_o !== v && n < lim) begin
         tick();
         n++;
      end
      if (count_o !== v) chk("wait_count_timeout", count_o, v);
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 7))
         0: return 5'd9;
         1: return 5'd11;
         2: return 5'd12;
         3: return 5'd13;
         4: return 5'd14;
         5: return 5'd15;
         6: return 5'd16;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         int r;
         we     = 1'($urandom_range(0, 1));
         waddr  = pick_reg();
         wdata  = $urandom();
         raddr  = ($urandom_range(0, 3) == 0) ? waddr : pick_reg();
         int_in = 6'($urandom());
         pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         ds     = 1'($urandom_range(0, 1));
         r      = $urandom_range(0, 15);
         if (r <= 11)      et = 32'd0;
         else if (r <= 14) et = codes[$urandom_range(0, 5)];
         else              et = 32'hE;
         tick();
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      raddr = 5'd0; int_in = 6'd0;
      model_reset();
      #1 rst = 1'b0;
      #2;
      chk("rst_count",  count_o,  32'd0);
      chk("rst_status", status_o, 32'h1000_0000);
      chk("rst_cause",  cause_o,  32'd0);
      chk("rst_epc",    epc_o,    32'd0);
      chk("rst_tint",   {31'd0, timer_int_o}, 32'd0);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;

      // idle 5 cycles after release
      repeat (5) tick();
`ifdef CP0_TIMER_EN
      chk("idle5_count", count_o, 32'd5);
`else
      chk("idle5_count", count_o, 32'd0);
`endif
      chk("idle5_status", status_o, 32'h1000_0000);
      chk("idle5_prid",   prid_o,   32'h004C_0102);
      chk("idle5_tint",   {31'd0, timer_int_o}, 32'd0);

`ifdef CP0_TIMER_EN
      // timer: Compare=20 written at count 10
      wait_count(32'd10, 20);
      wr_reg(5'd11, 32'd20);
      wait_count(32'd20, 30);
      chk("pre_match_tint", {31'd0, timer_int_o}, 32'd0);
      tick();
      chk("match_tint", {31'd0, timer_int_o}, 32'd1);
      repeat (3) tick();
      chk("sticky_tint", {31'd0, timer_int_o}, 32'd1);
      wr_reg(5'd11, 32'd100);
      chk("clear_tint", {31'd0, timer_int_o}, 32'd0);
      // write Compare exactly on a match cycle: clear wins
      wait_count(32'd100, 200);
      wr_reg(5'd11, 32'd200);
      chk("clear_wins_tint", {31'd0, timer_int_o}, 32'd0);
      // wrap
      wr_reg(5'd9, 32'hFFFF_FFFF);
      chk("count_load", count_o, 32'hFFFF_FFFF);
      tick();
      chk("count_wrap", count_o, 32'd0);
`endif

      // Cause write with IP pins
      int_in = 6'b000011;
      raddr  = 5'd13;
      we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF;
      #1 chk("cause_bypass", rdata_o, 32'h00C0_0300);
      tick();
      idle();
      chk("cause_write", cause_o, 32'h00C0_0F00);

      // syscall in delay slot
      et = 32'h8; pc = 32'h8000_0100; ds = 1'b1;
      tick();
      idle();
      chk("sys_epc",  epc_o, 32'h8000_00FC);
      chk("sys_bd",   {31'd0, cause_o[31]}, 32'd1);
      chk("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
      chk("sys_exl",  {31'd0, status_o[1]}, 32'd1);
      // nested exception leaves EPC alone
      et = 32'h1; pc = 32'h0000_0200; ds = 1'b0;
      tick();
      idle();
      chk("nested_epc", epc_o, 32'h8000_00FC);
      chk("nested_bd",  {31'd0, cause_o[31]}, 32'd1);
      et = 32'hE;
      tick();
      idle();
      chk("eret_status", status_o, 32'h1000_0000);

      // write suppressed by same-cycle overflow
      we = 1'b1; waddr = 5'd14; wdata = 32'h1234;
      et = 32'hC; pc = 32'h0000_0400; ds = 1'b0;
      tick();
      idle();
      chk("ov_epc",  epc_o, 32'h0000_0400);
      chk("ov_code", {27'd0, cause_o[6:2]}, 32'd12);
      et = 32'hE;
      tick();
      idle();

      // EPC bypass
      we = 1'b1; waddr = 5'd14; wdata = 32'hABCD; raddr = 5'd14;
      #1 chk("epc_bypass", rdata_o, 32'h0000_ABCD);
      tick();
      idle();
      chk("epc_written", epc_o, 32'h0000_ABCD);

      rand_cycles(2000);

      // async reset mid-operation
`ifdef CP0_TIMER_EN
      wr_reg(5'd11, 32'd52);
      wr_reg(5'd9, 32'd50);
      repeat (3) tick();
      chk("pre_rst_tint", {31'd0, timer_int_o}, 32'd1);
`endif
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_tint",   {31'd0, timer_int_o}, 32'd0);
      chk("mid_rst_count",  count_o,   32'd0);
      chk("mid_rst_cmp",    compare_o, 32'd0);
      chk("mid_rst_status", status_o,  32'h1000_0000);
      chk("mid_rst_cause",  cause_o,   32'd0);
      chk("mid_rst_epc",    epc_o,     32'd0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b1;

      rand_cycles(300);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
